axi4_write_arbiter: RTL

AXI4_WRITE_ARBITER -- requirements
Module: axi4_write_arbiter

---
 rtl/axi4_write_arbiter_pkg.sv | 17 +
 rtl/axi4_write_arbiter_rr_pick.sv | 32 +++
 rtl/axi4_write_arbiter.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/axi4_write_arbiter_pkg.sv
// Shared types and default sizing for the AXI4 write arbiter.
// WR_ARB_TIMEOUT_EN (in the top) enables the completion watchdog.
package axi4_write_arbiter_pkg;

  localparam int DEF_NUM_REQ        = 4;
  localparam int DEF_ADDR_WIDTH     = 32;
  localparam int DEF_DATA_WIDTH     = 32;
  localparam int DEF_TIMEOUT_CYCLES = 1024;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_DONE,
    ST_RESP
  } arb_state_e;

endpackage

// File: rtl/axi4_write_arbiter_rr_pick.sv
// Combinational round-robin pick: lowest requester above last_grant,
// otherwise the lowest requester overall (wrap-around).
module rr_pick #(
  parameter int P_NUM_REQ = 4,
  parameter int P_IDX_W   = $clog2(P_NUM_REQ)
) (
  input  logic [P_NUM_REQ-1:0] req,
  input  logic [P_IDX_W-1:0]   last_grant,
  output logic                 vld,
  output logic [P_IDX_W-1:0]   idx
);

  logic [P_NUM_REQ-1:0] above;
  logic                 hit_hi;

  always_comb begin
    above = '0;
    for (int i = 0; i < P_NUM_REQ; i++)
      above[i] = req[i] && (i > int'(last_grant));
  end

  assign hit_hi = |above;
  assign vld    = |req;

  // Scan downward so the lowest qualifying index wins.
  always_comb begin
    idx = '0;
    for (int i = P_NUM_REQ-1; i >= 0; i--)
      if (hit_hi ? above[i] : req[i]) idx = P_IDX_W'(i);
  end

endmodule

// File: rtl/axi4_write_arbiter.sv
// Round-robin arbiter funnelling N write requesters into one axi4_master port.
// Optional WR_ARB_TIMEOUT_EN adds a WAIT_DONE watchdog that forces an error response.
module axi4_write_arbiter
  import axi4_write_arbiter_pkg::*;
#(
  parameter int P_NUM_REQ        = DEF_NUM_REQ,
  parameter int P_ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int P_DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int P_TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                              CLOCK,
  input  logic                              RESET,
  input  logic [P_NUM_REQ-1:0]              REQ_VALID,
  input  logic [P_NUM_REQ*P_ADDR_WIDTH-1:0] REQ_ADDR,
  input  logic [P_NUM_REQ*P_DATA_WIDTH-1:0] REQ_DATA,
  output logic [P_NUM_REQ-1:0]              REQ_READY,
  output logic [P_NUM_REQ-1:0]              REQ_DONE,
  output logic [P_NUM_REQ-1:0]              REQ_ERROR,
  output logic [P_ADDR_WIDTH-1:0]           WRITE_ADDR,
  output logic [P_DATA_WIDTH-1:0]           WRITE_DATA,
  output logic                              WRITE_START,
  input  logic                              WRITE_READY,
  input  logic                              WRITE_DONE,
  input  logic                              WRITE_ERROR,
  output logic [$clog2(P_NUM_REQ)-1:0]      GRANT_ID,
  output logic                              BUSY,
  output logic                              TIMEOUT
);

  localparam int IW = $clog2(P_NUM_REQ);

  logic [P_NUM_REQ-1:0][P_ADDR_WIDTH-1:0] req_addr_a;
  logic [P_NUM_REQ-1:0][P_DATA_WIDTH-1:0] req_data_a;

  assign req_addr_a = REQ_ADDR;
  assign req_data_a = REQ_DATA;

  arb_state_e                state_q, state_nx;
  logic [IW-1:0]             last_q, last_nx;
  logic [IW-1:0]             grant_q, grant_nx;
  logic [P_ADDR_WIDTH-1:0]   addr_q, addr_nx;
  logic [P_DATA_WIDTH-1:0]   data_q, data_nx;
  logic [P_NUM_REQ-1:0]      ready_q, ready_nx;
  logic [P_NUM_REQ-1:0]      done_q, done_nx;
  logic [P_NUM_REQ-1:0]      rerr_q, rerr_nx;
  logic                      start_q;
  logic                      pick_vld;
  logic [IW-1:0]             pick_idx;
  logic                      tmo_hit;
  logic                      tmo_fire;

  rr_pick #(
    .P_NUM_REQ (P_NUM_REQ),
    .P_IDX_W   (IW)
  ) u_rr_pick (
    .req        (REQ_VALID),
    .last_grant (last_q),
    .vld        (pick_vld),
    .idx        (pick_idx)
  );

  always_comb begin
    state_nx = state_q;
    last_nx  = last_q;
    grant_nx = grant_q;
    addr_nx  = addr_q;
    data_nx  = data_q;
    ready_nx = '0;
    done_nx  = '0;
    rerr_nx  = '0;
    tmo_fire = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          grant_nx           = pick_idx;
          addr_nx            = req_addr_a[pick_idx];
          data_nx            = req_data_a[pick_idx];
          ready_nx[pick_idx] = 1'b1;
          state_nx           = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (WRITE_READY) state_nx = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        // A real completion wins over a watchdog expiry in the same cycle.
        if (WRITE_DONE || WRITE_ERROR) begin
          state_nx         = ST_RESP;
          done_nx[grant_q] = 1'b1;
          rerr_nx[grant_q] = WRITE_ERROR;
        end else if (tmo_hit) begin
          state_nx         = ST_RESP;
          done_nx[grant_q] = 1'b1;
          rerr_nx[grant_q] = 1'b1;
          tmo_fire         = 1'b1;
        end
      end
      ST_RESP: begin
        last_nx  = grant_q;
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      last_q  <= IW'(P_NUM_REQ-1);
      grant_q <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      ready_q <= '0;
      done_q  <= '0;
      rerr_q  <= '0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_nx;
      last_q  <= last_nx;
      grant_q <= grant_nx;
      addr_q  <= addr_nx;
      data_q  <= data_nx;
      ready_q <= ready_nx;
      done_q  <= done_nx;
      rerr_q  <= rerr_nx;
      start_q <= (state_nx == ST_ISSUE);
    end
  end

`ifdef WR_ARB_TIMEOUT_EN
  localparam int TW = $clog2(P_TIMEOUT_CYCLES+1);

  logic [TW-1:0] tmo_cnt;
  logic          timeout_q;

  // Counts completed WAIT_DONE cycles; expiry lands on the last allowed one.
  assign tmo_hit = (tmo_cnt == TW'(P_TIMEOUT_CYCLES-1));

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      tmo_cnt   <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state_q == ST_WAIT_DONE && state_nx == ST_WAIT_DONE)
        tmo_cnt <= tmo_cnt + TW'(1);
      else
        tmo_cnt <= '0;
      if (tmo_fire) timeout_q <= 1'b1;
    end
  end

  assign TIMEOUT = timeout_q;
`else
  assign tmo_hit = 1'b0;
  assign TIMEOUT = 1'b0;
`endif

  assign REQ_READY   = ready_q;
  assign REQ_DONE    = done_q;
  assign REQ_ERROR   = rerr_q;
  assign WRITE_ADDR  = addr_q;
  assign WRITE_DATA  = data_q;
  assign WRITE_START = start_q;
  assign GRANT_ID    = grant_q;
  assign BUSY        = (state_q != ST_IDLE);

endmodule
